// File: rtl/run_detect_sched.sv
// Round-robin scheduler sharing one run detector across NCH serial bit streams.
// Optional per-channel hit counters are enabled with `define RUN_DETECT_STATS_EN.
module run_detect_sched #(
    parameter int NCH     = 4,
    parameter int RUN_LEN = 2,
    parameter int CHW     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [NCH-1:0]   req_valid,
    input  logic [NCH-1:0]   req_bit,
    output logic [NCH-1:0]   req_ready,
    output logic             det_valid,
    output logic [CHW-1:0]   det_ch,
    output logic             det_bit,
    output logic             busy
`ifdef RUN_DETECT_STATS_EN
    ,
    input  logic [CHW-1:0]   stat_sel,
    output logic [15:0]      stat_cnt
`endif
);

    localparam int CNTW = $clog2(RUN_LEN + 1);
    localparam logic [CNTW-1:0] RUN_MAX = CNTW'(RUN_LEN);
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    logic [NCH-1:0]  has_prev_q, has_prev_d;
    logic [NCH-1:0]  last_q, last_d;
    logic [CNTW-1:0] cnt_q [NCH];
    logic [CNTW-1:0] cnt_d [NCH];
    logic [CHW-1:0]  ptr_q, ptr_d;
    logic            det_valid_q, det_valid_d;
    logic [CHW-1:0]  det_ch_q, det_ch_d;
    logic            det_bit_q, det_bit_d;

    logic            gnt_found;
    logic [CHW-1:0]  gnt_idx;
    logic [CHW-1:0]  scan_idx;
    logic            accept;
    logic            acc_bit;
    logic            acc_match;
    logic [CNTW-1:0] acc_cnt;

    // Scan upward from the pointer with wrap; first requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            scan_idx = CHW'((32'(ptr_q) + i) % NCH);
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    assign accept    = en && !clr && gnt_found;
    assign req_ready = accept ? (NCH'(1) << gnt_idx) : '0;
    assign busy      = en && (|req_valid);

    assign acc_bit   = req_bit[gnt_idx];
    assign acc_match = has_prev_q[gnt_idx] && (acc_bit == last_q[gnt_idx]);

    always_comb begin
        acc_cnt = CNT_ONE;
        if (acc_match) begin
            acc_cnt = (cnt_q[gnt_idx] == RUN_MAX) ? RUN_MAX : cnt_q[gnt_idx] + CNT_ONE;
        end
    end

    always_comb begin
        has_prev_d  = has_prev_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        det_valid_d = 1'b0;
        det_ch_d    = det_ch_q;
        det_bit_d   = det_bit_q;
        if (clr) begin
            has_prev_d = '0;
            last_d     = '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_d[i] = '0;
            end
        end else if (accept) begin
            has_prev_d[gnt_idx] = 1'b1;
            last_d[gnt_idx]     = acc_bit;
            cnt_d[gnt_idx]      = acc_cnt;
            ptr_d = (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + CHW'(1);
            if (acc_cnt == RUN_MAX) begin
                det_valid_d = 1'b1;
                det_ch_d    = gnt_idx;
                det_bit_d   = acc_bit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            has_prev_q  <= '0;
            last_q      <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
            ptr_q       <= '0;
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
            det_bit_q   <= 1'b0;
        end else begin
            has_prev_q  <= has_prev_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            det_valid_q <= det_valid_d;
            det_ch_q    <= det_ch_d;
            det_bit_q   <= det_bit_d;
        end
    end

    assign det_valid = det_valid_q;
    assign det_ch    = det_ch_q;
    assign det_bit   = det_bit_q;

`ifdef RUN_DETECT_STATS_EN
    logic [15:0] hits_q [NCH];

    // Counts cycles with a detect presented for each channel, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                hits_q[i] <= '0;
            end
        end else if (clr) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                hits_q[i] <= '0;
            end
        end else if (det_valid_q && (hits_q[det_ch_q] != '1)) begin
            hits_q[det_ch_q] <= hits_q[det_ch_q] + 16'd1;
        end
    end

    assign stat_cnt = hits_q[stat_sel];
`endif

endmodule

// File: tb/tb_run_detect_sched.sv
// Scoreboard bench for run_detect_sched: a history-based model predicts grants
// and detects; a separate monitor compares DUT outputs against queued expectations.
module tb_run_detect_sched;

    localparam int NCH     = 4;
    localparam int RUN_LEN = 2;
    localparam int CHW     = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           clr = 1'b0;
    logic [NCH-1:0] req_valid = '0;
    logic [NCH-1:0] req_bit = '0;
    logic [NCH-1:0] req_ready;
    logic           det_valid;
    logic [CHW-1:0] det_ch;
    logic           det_bit;
    logic           busy;
`ifdef RUN_DETECT_STATS_EN
    logic [CHW-1:0] stat_sel = '0;
    logic [15:0]    stat_cnt;
`endif

    always #5 clk = ~clk;

    run_detect_sched #(
        .NCH     (NCH),
        .RUN_LEN (RUN_LEN),
        .CHW     (CHW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .req_valid (req_valid),
        .req_bit   (req_bit),
        .req_ready (req_ready),
        .det_valid (det_valid),
        .det_ch    (det_ch),
        .det_bit   (det_bit),
        .busy      (busy)
`ifdef RUN_DETECT_STATS_EN
        ,
        .stat_sel  (stat_sel),
        .stat_cnt  (stat_cnt)
`endif
    );

    typedef struct {
        logic [NCH-1:0] rdy;
        logic           bsy;
    } rdy_exp_t;

    typedef struct {
        logic           v;
        logic [CHW-1:0] ch;
        logic           b;
    } det_exp_t;

    rdy_exp_t rdy_q [$];
    det_exp_t det_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: recent accepted bits per channel, round-robin pointer,
    // and the last reported detect channel/bit.
    bit             hist [NCH][$];
    int             m_ptr = 0;
    logic [CHW-1:0] m_ch  = '0;
    logic           m_bit = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) hist[i].delete();
        m_ptr = 0;
        m_ch  = '0;
        m_bit = 1'b0;
    endfunction

    // One clock of stimulus; returns the model's granted channel or -1.
    task automatic step(input logic e, input logic c, input logic [NCH-1:0] v,
                        input logic [NCH-1:0] b, output int g);
        rdy_exp_t r;
        det_exp_t d;
        bit       all_eq;
        @(negedge clk);
        en = e; clr = c; req_valid = v; req_bit = b;
        #1;
        g = -1;
        if (e && !c) begin
            for (int i = 0; i < NCH; i++) begin
                int idx;
                idx = (m_ptr + i) % NCH;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        r.rdy = '0;
        if (g >= 0) r.rdy[g] = 1'b1;
        r.bsy = e && (v != '0);
        d.v = 1'b0;
        if (c) begin
            for (int i = 0; i < NCH; i++) hist[i].delete();
        end else if (g >= 0) begin
            hist[g].push_back(b[g]);
            if (hist[g].size() > RUN_LEN) void'(hist[g].pop_front());
            all_eq = 1'b1;
            foreach (hist[g][k]) if (hist[g][k] != b[g]) all_eq = 1'b0;
            if (hist[g].size() == RUN_LEN && all_eq) begin
                d.v   = 1'b1;
                m_ch  = CHW'(g);
                m_bit = b[g];
            end
            m_ptr = (g + 1) % NCH;
        end
        d.ch = m_ch;
        d.b  = m_bit;
        rdy_q.push_back(r);
        det_q.push_back(d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 1'b0; clr = 1'b0; req_valid = '0; req_bit = '0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: combinational grant before the edge, registered detect after it.
    initial begin
        rdy_exp_t r;
        det_exp_t d;
        forever begin
            @(negedge clk);
            #3;
            if (rdy_q.size() > 0) begin
                r = rdy_q.pop_front();
                chk("req_ready", 32'(req_ready), 32'(r.rdy));
                chk("busy", 32'(busy), 32'(r.bsy));
            end
            @(posedge clk);
            #1;
            if (det_q.size() > 0) begin
                d = det_q.pop_front();
                chk("det_valid", 32'(det_valid), 32'(d.v));
                chk("det_ch", 32'(det_ch), 32'(d.ch));
                chk("det_bit", 32'(det_bit), 32'(d.b));
            end
        end
    end

    initial begin
        int             g;
        logic [NCH-1:0] pv;
        logic [NCH-1:0] pb;
        logic [4:0]     seq;

        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset det_valid", 32'(det_valid), 32'd0);
        chk("reset det_ch", 32'(det_ch), 32'd0);
        chk("reset det_bit", 32'(det_bit), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd0);

        // Single channel run 0,0,1,1,1
        seq = 5'b11100;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'b0001, {3'b000, seq[i]}, g);

        // Fairness with everyone requesting from reset
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'b1111, 4'($urandom_range(15, 0)), g);

        // Interleaved contexts on ch1/ch2
        do_reset();
        step(1'b1, 1'b0, 4'b0010, 4'b0010, g);
        step(1'b1, 1'b0, 4'b0100, 4'b0100, g);
        step(1'b1, 1'b0, 4'b0010, 4'b0010, g);

        // clr in the middle of a run
        do_reset();
        step(1'b1, 1'b0, 4'b0001, 4'b0000, g);
        step(1'b1, 1'b1, 4'b0001, 4'b0000, g);
        step(1'b1, 1'b0, 4'b0001, 4'b0000, g);
        step(1'b1, 1'b0, 4'b0001, 4'b0000, g);

        // en gating with all requests pending
        step(1'b1, 1'b0, 4'b1111, 4'b1111, g);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b1111, 4'b1111, g);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'b1111, 4'b1111, g);

        // Asynchronous reset while a detect is presented
        do_reset();
        step(1'b1, 1'b0, 4'b0001, 4'b0001, g);
        step(1'b1, 1'b0, 4'b0001, 4'b0001, g);
        @(negedge clk);
        en = 1'b0; req_valid = '0; req_bit = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("async det_valid", 32'(det_valid), 32'd0);
        chk("async det_ch", 32'(det_ch), 32'd0);
        chk("async det_bit", 32'(det_bit), 32'd0);
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        step(1'b1, 1'b0, 4'b0001, 4'b0001, g);
        step(1'b1, 1'b0, 4'b0001, 4'b0001, g);

        // Random traffic; a pending bit is held until accepted
        pv = '0;
        pb = '0;
        for (int n = 0; n < 400; n++) begin
            logic e;
            logic c;
            for (int ch = 0; ch < NCH; ch++) begin
                if (!pv[ch] && $urandom_range(1, 0) == 1) begin
                    pv[ch] = 1'b1;
                    pb[ch] = 1'($urandom_range(1, 0));
                end
            end
            e = ($urandom_range(7, 0) != 0);
            c = ($urandom_range(24, 0) == 0);
            step(e, c, pv, pb, g);
            if (g >= 0) pv[g] = 1'b0;
        end

        step(1'b1, 1'b0, '0, '0, g);
        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
